// File: rtl/u2_sm_conv_pipe_if.sv
// Handshake bundle for the U2/SM converter: input word channel
// and converted-word output channel.
interface u2_sm_conv_pipe_if #(
   parameter int N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         out_err;

   modport master (
      output in_valid,
      output in_data,
      output in_mode,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_err
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_mode,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_err
   );
endinterface

// File: rtl/u2_sm_conv_pipe.sv
// U2 <-> sign-magnitude converter, 1-cycle datapath, 2-entry skid buffer.
// CONV_SAT_EN: U2->SM overflow saturates to {1,1..1} instead of 0.
module u2_sm_conv_pipe #(
   parameter int N     = 8,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   u2_sm_conv_pipe_if.slave     bus,
   input  logic                 err_clr,
   output logic [CNT_W-1:0]     err_cnt
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic             r_in_ready;
   logic [N-1:0]     r_m_data;
   logic             r_m_err;
   logic [N-1:0]     r_s_data;
   logic             r_s_err;
   logic [CNT_W-1:0] r_cnt;

   logic [N-1:0] w_neg;
   logic [N-1:0] w_conv;
   logic         w_err;
   logic         w_low_zero;
   logic         w_accept;
   logic         w_pop;

   assign w_accept = bus.in_valid & r_in_ready;
   assign w_pop    = bus.out_valid & bus.out_ready;

   always_comb begin
      w_neg      = ~bus.in_data + ONE_N;
      w_low_zero = (bus.in_data[N-2:0] == '0);
      w_conv     = bus.in_data;
      w_err      = 1'b0;
      if (bus.in_data[N-1]) begin
         if (w_low_zero) begin
            // most negative U2 has no SM form; SM -0 normalises to 0
            if (!bus.in_mode) begin
               w_err = 1'b1;
`ifdef CONV_SAT_EN
               w_conv = '1;
`else
               w_conv = '0;
`endif
            end else begin
               w_conv = '0;
            end
         end else if (!bus.in_mode) begin
            w_conv = {1'b1, w_neg[N-2:0]};
         end else begin
            w_conv = ~{1'b0, bus.in_data[N-2:0]} + ONE_N;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b1;
         r_m_data   <= '0;
         r_m_err    <= 1'b0;
         r_s_data   <= '0;
         r_s_err    <= 1'b0;
      end else begin
         unique case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_state  <= ONE;
                  r_m_data <= w_conv;
                  r_m_err  <= w_err;
               end
            end
            ONE: begin
               if (w_accept && !w_pop) begin
                  r_state    <= TWO;
                  r_s_data   <= w_conv;
                  r_s_err    <= w_err;
                  r_in_ready <= 1'b0;
               end else if (w_pop && !w_accept) begin
                  r_state <= EMPTY;
               end else if (w_pop && w_accept) begin
                  r_m_data <= w_conv;
                  r_m_err  <= w_err;
               end
            end
            TWO: begin
               if (w_pop) begin
                  r_state    <= ONE;
                  r_m_data   <= r_s_data;
                  r_m_err    <= r_s_err;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= EMPTY;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   // clear wins over a coincident errored pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (err_clr) begin
         r_cnt <= '0;
      end else if (w_pop && r_m_err && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = (r_state != EMPTY);
   assign bus.out_data  = r_m_data;
   assign bus.out_err   = r_m_err;
   assign err_cnt       = r_cnt;
endmodule

// File: tb/tb_u2_sm_conv_pipe.sv
// Bench for u2_sm_conv_pipe: vector table, stream/backpressure
// scoreboard, counter saturation/clear and reset-in-TWO sequences.
module tb_u2_sm_conv_pipe;
   logic       clk;
   logic       rst_n;
   logic       err_clr;
   logic [7:0] err_cnt;

   u2_sm_conv_pipe_if #(.N(8)) bus ();

   u2_sm_conv_pipe #(.N(8), .CNT_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .err_clr (err_clr),
      .err_cnt (err_cnt)
   );

`ifdef CONV_SAT_EN
   localparam logic [7:0] OVF = 8'hFF;
`else
   localparam logic [7:0] OVF = 8'h00;
`endif

   typedef struct {
      logic [7:0] din;
      logic       mode;
      logic [7:0] dout;
      logic       err;
   } vec_t;

   int         n_cmp;
   int         n_bad;
   int         exp_cnt;
   bit         rnd_bp;
   logic [8:0] sb[$];
   vec_t       vt[11];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] model(input logic [7:0] x,
                                        input logic m);
      int v;
      int mag;
      logic [7:0] r;
      if (!m) begin
         v = $signed(x);
         if (v == -128) return {1'b1, OVF};
         mag = (v < 0) ? -v : v;
         r = {(v < 0), mag[6:0]};
      end else begin
         mag = int'(x[6:0]);
         v = x[7] ? -mag : mag;
         r = v[7:0];
      end
      return {1'b0, r};
   endfunction

   task automatic send(input logic [7:0] d, input logic m,
                       input logic [8:0] exp);
      bit done;
      done = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = m;
      for (int t = 0; t < 500 && !done; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(exp);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      chk("send_accept", 32'(done), 32'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && sb.size() > 0; t++)
         @(negedge clk);
      chk("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            e = 9'd0;
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  chk("pop_unexpected", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("pop_word", {bus.out_err, bus.out_data}, e);
               end
            end
            if (err_clr) exp_cnt = 0;
            else if (e[8] && exp_cnt < 255) exp_cnt++;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      logic [7:0] d;
      logic       m;
      n_cmp = 0;
      n_bad = 0;
      exp_cnt = 0;
      rnd_bp = 0;
      rst_n = 1'b0;
      err_clr = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      bus.in_mode = 1'b0;
      bus.out_ready = 1'b1;

      vt[0]  = '{8'hFB, 1'b0, 8'h85, 1'b0};
      vt[1]  = '{8'h85, 1'b1, 8'hFB, 1'b0};
      vt[2]  = '{8'h80, 1'b1, 8'h00, 1'b0};
      vt[3]  = '{8'h05, 1'b0, 8'h05, 1'b0};
      vt[4]  = '{8'hFF, 1'b0, 8'h81, 1'b0};
      vt[5]  = '{8'h81, 1'b0, 8'hFF, 1'b0};
      vt[6]  = '{8'hFF, 1'b1, 8'h81, 1'b0};
      vt[7]  = '{8'h81, 1'b1, 8'hFF, 1'b0};
      vt[8]  = '{8'h7F, 1'b1, 8'h7F, 1'b0};
      vt[9]  = '{8'h00, 1'b0, 8'h00, 1'b0};
      vt[10] = '{8'h80, 1'b0, OVF,   1'b1};

      fork
         monitor();
      join_none

      #12;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         send(vt[i].din, vt[i].mode, {vt[i].err, vt[i].dout});
         if (i == 0) begin
            chk("lat_valid", 32'(bus.out_valid), 32'd1);
            chk("lat_data", 32'(bus.out_data), 32'h85);
            chk("lat_cnt", 32'(err_cnt), 32'd0);
         end
      end
      drain();
      chk("cnt_after_ovf", 32'(err_cnt), 32'd1);

      bus.out_ready = 1'b0;
      send(8'h01, 1'b0, model(8'h01, 1'b0));
      send(8'h02, 1'b0, model(8'h02, 1'b0));
      fork
         send(8'h03, 1'b0, model(8'h03, 1'b0));
         begin
            repeat (3) @(negedge clk);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_depth", sb.size(), 2);
            chk("stall_hold", 32'(bus.out_data), 32'h01);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();

      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      rnd_bp = 1;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         d = 8'($urandom);
         m = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) d = 8'h80;
         send(d, m, model(d, m));
      end
      rnd_bp = 0;
      @(posedge clk);
      #3;
      bus.out_ready = 1'b1;
      drain();
      chk("rnd_err_cnt", 32'(err_cnt), 32'(exp_cnt));

      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      for (int i = 0; i < 260; i++)
         send(8'h80, 1'b0, {1'b1, OVF});
      drain();
      chk("cnt_saturate", 32'(err_cnt), 32'hFF);

      bus.out_ready = 1'b0;
      send(8'h80, 1'b0, {1'b1, OVF});
      chk("clr_pre_cnt", 32'(err_cnt), 32'hFF);
      bus.out_ready = 1'b1;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      chk("clr_vs_pop", 32'(err_cnt), 32'd0);
      chk("clr_popped", sb.size(), 0);

      bus.out_ready = 1'b0;
      send(8'h11, 1'b0, model(8'h11, 1'b0));
      send(8'h22, 1'b1, model(8'h22, 1'b1));
      chk("two_in_ready", 32'(bus.in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("arst_out_data", 32'(bus.out_data), 32'd0);
      sb.delete();
      exp_cnt = 0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(8'hC0, 1'b0, model(8'hC0, 1'b0));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
